// File: rtl/fetch_unit_pkg.sv
// Shared constants and next-PC select encodings for the fetch stage.
package fetch_unit_pkg;

    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_op_t;

endpackage

// File: rtl/fetch_unit_npc.sv
// Next-PC selection: sequential, taken branch, j/jal or jr target.
// Branch and jump targets use the IF/ID PC+4, so the delay-slot
// instruction (currently being fetched) is never skipped.
module npc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] if_id_pc4,
    input  logic [1:0]  npc_op,
    input  logic        br,
    input  logic [15:0] id_imm16,
    input  logic [25:0] id_jidx,
    input  logic [31:0] jr_target,
    output logic [31:0] seq_pc4,
    output logic [31:0] next_pc
);

    npc_op_t     op;
    logic [31:0] br_target;

    assign op = npc_op_t'(npc_op);

    // Target arithmetic is 32-bit modulo; sequential is the default choice.
    always_comb begin
        seq_pc4   = pc + 32'd4;
        br_target = if_id_pc4 + {{14{id_imm16[15]}}, id_imm16, 2'b00};
        next_pc   = seq_pc4;
        case (op)
            NPC_BR: begin
                if (br) begin
                    next_pc = br_target;
                end
            end
            NPC_J:   next_pc = {if_id_pc4[31:28], id_jidx, 2'b00};
            NPC_JR:  next_pc = jr_target;
            default: next_pc = seq_pc4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and
// misaligned-fetch flag. Exceptions override stalls; stalls drop redirects.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        exc_req,
    input  logic [1:0]  npc_op,
    input  logic        br,
    input  logic [15:0] id_imm16,
    input  logic [25:0] id_jidx,
    input  logic [31:0] jr_target,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_pc,
    output logic        addr_err
);

    logic [31:0] pc;
    logic [31:0] seq_pc4;
    logic [31:0] next_pc;
    logic        fetch_misaligned;

    assign imem_addr        = pc;
    assign fetch_misaligned = (pc[1:0] != 2'b00);

    npc u_npc (
        .pc        (pc),
        .if_id_pc4 (if_id_pc4),
        .npc_op    (npc_op),
        .br        (br),
        .id_imm16  (id_imm16),
        .id_jidx   (id_jidx),
        .jr_target (jr_target),
        .seq_pc4   (seq_pc4),
        .next_pc   (next_pc)
    );

    // PC and IF/ID update: reset, exception, stall hold, then normal advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= PC_RESET;
            if_id_instr <= NOP_WORD;
            if_id_pc4   <= PC_RESET + 32'd4;
            if_id_pc    <= PC_RESET;
            addr_err    <= 1'b0;
        end else if (exc_req) begin
            pc          <= EXC_VECTOR;
            if_id_instr <= NOP_WORD;
            if_id_pc4   <= seq_pc4;
            if_id_pc    <= pc;
            addr_err    <= 1'b0;
        end else if (!stall) begin
            pc          <= next_pc;
            if_id_instr <= fetch_misaligned ? NOP_WORD : imem_rdata;
            if_id_pc4   <= seq_pc4;
            if_id_pc    <= pc;
            addr_err    <= fetch_misaligned;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random steps,
// each checked against a behavioural model of the fetch stage.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        exc_req;
    logic [1:0]  npc_op;
    logic        br;
    logic [15:0] id_imm16;
    logic [25:0] id_jidx;
    logic [31:0] jr_target;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_pc;
    logic        addr_err;

    logic [31:0] salt;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    logic [31:0] m_pc, m_instr, m_pc4, m_ifpc;
    logic        m_err;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .exc_req     (exc_req),
        .npc_op      (npc_op),
        .br          (br),
        .id_imm16    (id_imm16),
        .id_jidx     (id_jidx),
        .jr_target   (jr_target),
        .imem_rdata  (imem_rdata),
        .imem_addr   (imem_addr),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_pc    (if_id_pc),
        .addr_err    (addr_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] s);
        return (a * 32'h9E37_79B1) ^ s ^ 32'h1234_5677;
    endfunction

    // Instruction memory answers combinationally from the current PC
    assign imem_rdata = mem_word(imem_addr, salt);

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input bit skip_ifid_pcs);
        checkVal({tag, ".imem_addr"}, imem_addr, m_pc);
        checkVal({tag, ".if_id_instr"}, if_id_instr, m_instr);
        if (!skip_ifid_pcs) begin
            checkVal({tag, ".if_id_pc4"}, if_id_pc4, m_pc4);
            checkVal({tag, ".if_id_pc"}, if_id_pc, m_ifpc);
        end
        checkVal({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, m_err});
    endtask

    task automatic applyStimulus(input logic rst, input logic stl, input logic exc,
                                 input logic [1:0] op, input logic b,
                                 input logic [15:0] imm, input logic [25:0] jidx,
                                 input logic [31:0] jr);
        reset     = rst;
        stall     = stl;
        exc_req   = exc;
        npc_op    = op;
        br        = b;
        id_imm16  = imm;
        id_jidx   = jidx;
        jr_target = jr;
    endtask

    // Advance one clock: predict from the fetch rules, then compare.
    task automatic stepCycle(input string tag);
        logic [31:0] n_pc, n_instr, n_pc4, n_ifpc;
        logic        n_err_flag;
        int          off;
        n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_ifpc = m_ifpc; n_err_flag = m_err;
        if (reset) begin
            n_pc = 32'h3000; n_instr = 0; n_pc4 = 32'h3004; n_ifpc = 32'h3000; n_err_flag = 0;
        end else if (exc_req) begin
            n_pc = 32'h4180; n_instr = 0; n_pc4 = m_pc + 4; n_ifpc = m_pc; n_err_flag = 0;
        end else if (!stall) begin
            case (npc_op)
                2'd1: begin
                    off  = int'($signed(id_imm16)) * 4;
                    n_pc = br ? m_pc4 + 32'(off) : m_pc + 4;
                end
                2'd2:    n_pc = (m_pc4 & 32'hF000_0000) | (32'(id_jidx) * 4);
                2'd3:    n_pc = jr_target;
                default: n_pc = m_pc + 4;
            endcase
            n_err_flag = (m_pc % 4) != 0;
            n_instr    = n_err_flag ? 32'd0 : mem_word(m_pc, salt);
            n_pc4      = m_pc + 4;
            n_ifpc     = m_pc;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_ifpc = n_ifpc; m_err = n_err_flag;
        checkOutput(tag, exc_req && !reset);
    endtask

    initial begin
        logic [31:0] slot_word;
        m_pc = 'x; m_instr = 'x; m_pc4 = 'x; m_ifpc = 'x; m_err = 1'bx;
        salt = 32'h0;
        applyStimulus(1, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        #2;

        // Reset values and sequential fetch
        stepCycle("reset");
        checkVal("reset_pc4_const", if_id_pc4, 32'h3004);
        applyStimulus(0, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        stepCycle("seq1");
        stepCycle("seq2");
        stepCycle("seq3");
        checkVal("seq_pc_const", imem_addr, 32'h300C);
        checkVal("seq_pc4_lag", if_id_pc4, 32'h300C);

        // Taken backward branch with delay slot
        applyStimulus(1, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        stepCycle("reset2");
        applyStimulus(0, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        stepCycle("pre_br1");
        stepCycle("pre_br2");
        slot_word = mem_word(32'h3008, salt);
        applyStimulus(0, 0, 0, 2'd1, 1, 16'hFFFE, 26'h0, 32'h0);
        stepCycle("br_taken");
        checkVal("br_target", imem_addr, 32'h3000);
        checkVal("delay_slot", if_id_instr, slot_word);

        // Not-taken branch
        applyStimulus(0, 0, 0, 2'd1, 0, 16'h0040, 26'h0, 32'h0);
        stepCycle("br_not_taken");
        checkVal("br_nt_pc", imem_addr, 32'h3004);

        // Jump with if_id_pc4 = 0x3010
        applyStimulus(1, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        stepCycle("reset3");
        applyStimulus(0, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        for (int i = 0; i < 4; i++) stepCycle("pre_j");
        applyStimulus(0, 0, 0, 2'd2, 0, 16'h0, 26'h0000C10, 32'h0);
        stepCycle("jump");
        checkVal("j_target", imem_addr, 32'h3040);

        // Stall drops a simultaneous jr, released stall takes it
        applyStimulus(0, 1, 0, 2'd3, 1, 16'h0, 26'h0, 32'h3100);
        stepCycle("stall1");
        stepCycle("stall2");
        checkVal("stall_hold_pc", imem_addr, 32'h3040);
        applyStimulus(0, 0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h3100);
        stepCycle("jr_after_stall");
        checkVal("jr_target", imem_addr, 32'h3100);

        // Exception wins over stall
        applyStimulus(0, 1, 1, 2'd3, 1, 16'h0, 26'h0, 32'h3200);
        stepCycle("exc_in_stall");
        checkVal("exc_vector", imem_addr, 32'h4180);

        // Misaligned jr target
        applyStimulus(0, 0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h3102);
        stepCycle("jr_misaligned");
        applyStimulus(0, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        stepCycle("fetch_misaligned");
        checkVal("addr_err_set", {31'd0, addr_err}, 32'd1);
        checkVal("addr_err_nop", if_id_instr, 32'h0);

        // Reset mid-run while stall and exception are both asserted
        applyStimulus(1, 1, 1, 2'd3, 1, 16'h0, 26'h0, 32'h5555);
        stepCycle("reset_mid");
        applyStimulus(0, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        checkVal("first_fetch", imem_addr, 32'h3000);
        stepCycle("post_reset");

        // PC+4 wraps silently at the top of the address space
        applyStimulus(0, 0, 0, 2'd3, 0, 16'h0, 26'h0, 32'hFFFF_FFFC);
        stepCycle("jr_top");
        applyStimulus(0, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        stepCycle("wrap");
        checkVal("wrap_pc", imem_addr, 32'h0);
        checkVal("wrap_pc4", if_id_pc4, 32'h0);

        // Random sequences against the model
        for (int i = 0; i < 300; i++) begin
            logic [31:0] jr;
            jr = $urandom;
            if ($urandom_range(7) != 0) jr[1:0] = 2'b00;
            salt = $urandom;
            applyStimulus(($urandom_range(49) == 0), ($urandom_range(3) == 0), 0,
                          2'($urandom_range(3)), 1'($urandom_range(1)),
                          16'($urandom), 26'($urandom), jr);
            stepCycle("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Port list, in order (name, direction, width, meaning):
- clk        in   1   rising-edge clock
- reset      in   1   synchronous, active-high reset
- stall      in   1   hazard-unit freeze of PC and IF/ID
- exc_req    in   1   redirect to the exception vector
- npc_op     in   2   ID-stage next-PC select: 00 seq, 01 branch, 10 j/jal, 11 jr
- br         in   1   branch-taken flag from the ID comparator
- id_imm16   in   16  branch offset of the ID instruction
- id_jidx    in   26  jump index of the ID instruction
- jr_target  in   32  forwarded rs value for jr
- imem_rdata in   32  instruction word, combinational read
- imem_addr  out  32  current PC
- if_id_instr out 32  IF/ID instruction register
- if_id_pc4  out  32  IF/ID PC+4 register
- if_id_pc   out  32  IF/ID PC register
- addr_err   out  1   registered flag: fetch PC misaligned

Function
REQ-003 imem_addr SHALL equal the PC register combinationally, with zero latency.
REQ-004 The PC SHALL update on each rising clk edge using this priority: reset, then exc_req, then stall, then redirect, then sequential.
REQ-005 When exc_req=1, the PC SHALL load EXC_VECTOR (0x0000_4180) and IF/ID SHALL load a NOP (0x0000_0000) on that same edge, regardless of stall.
REQ-006 When stall=1 and exc_req=0, the PC and all IF/ID registers SHALL hold their values; br and npc_op SHALL be ignored.
REQ-007 Redirect targets SHALL be computed with if_id_pc4 as the base:
- branch: taken when npc_op=01 and br=1; target = if_id_pc4 + (sign-extend(id_imm16) << 2)
- j/jal: target = {if_id_pc4[31:28], id_jidx, 2'b00}
- jr: target = jr_target
REQ-008 When npc_op=01 and br=0, or when npc_op=00, the next PC SHALL be PC+4.
REQ-009 The block SHALL implement a branch delay slot: the instruction fetched in the same cycle as a redirect SHALL enter IF/ID normally and SHALL NOT be flushed.
REQ-010 On every non-stalled, non-exception edge, IF/ID SHALL load imem_rdata, PC+4, and PC.
REQ-011 All adders SHALL be 32-bit modulo. PC+4 from 0xFFFF_FFFC SHALL wrap to 0x0000_0000 with no error flag.
REQ-012 addr_err SHALL register (PC[1:0]!=0) alongside IF/ID. When addr_err=1, IF/ID instr SHALL load a NOP. Only a jr target can raise it.
REQ-013 If stall and a redirect are asserted in the same cycle, the redirect SHALL be lost. The ID stage re-presents it on the next unstalled cycle.

Reset
REQ-014 On an edge with reset=1, the following SHALL apply:
- PC = PC_RESET (0x0000_3000)
- if_id_instr = 0
- if_id_pc4 = 0x0000_3004
- if_id_pc = 0x0000_3000
- addr_err = 0
REQ-015 Reset SHALL take effect mid-stall or mid-exception with no residual state. The first fetch after reset release SHALL use 0x0000_3000.

Structure
REQ-016 A shared package SHALL hold PC_RESET, EXC_VECTOR, NOP_WORD, and the npc_op encodings NPC_SEQ, NPC_BR, NPC_J, and NPC_JR.
REQ-017 Next-PC selection and target arithmetic SHALL live in one combinational sub-module, npc. The PC register and IF/ID register SHALL remain in fetch_unit.

Verification
REQ-018 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Sequential fetch: reset, then 3 free cycles -> imem_addr 0x3000, 0x3004, 0x3008, 0x300C; if_id_pc4 lags imem_addr by one cycle.
- Taken branch: if_id_pc4=0x3008, npc_op=01, br=1, imm16=0xFFFE -> next PC 0x3000; delay-slot word at 0x3008 is latched into IF/ID.
- Not-taken branch and jump: npc_op=01, br=0 -> next PC is PC+4. npc_op=10, jidx=0x0000C10, if_id_pc4=0x3010 -> next PC 0x0000_3040.
- Stall with simultaneous redirect: stall=1, npc_op=11, jr_target=0x3100 for 2 cycles -> PC and IF/ID unchanged; release stall with jr still presented -> PC 0x3100.
- Exception during stall: stall=1, exc_req=1 -> PC 0x4180, if_id_instr 0.
- Misaligned jr and mid-run reset: jr_target=0x3102 -> addr_err=1 and if_id_instr=0 on the next edge. Reset asserted mid-run -> all outputs return to REQ-014 values on the next edge.
